// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core pipeline: register index width and
// the destination tag carried per stage (also consumed by the bypass mux).
package mips_pkg;

    localparam int REG_W  = 5;
    localparam int BUSY_W = 6;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_W-1:0] dst;
        logic             we;
        logic             load;
    } dst_tag_t;

    // $zero is never a real destination, so its write enable is always dropped.
    function automatic dst_tag_t make_tag(input logic [REG_W-1:0] dst,
                                          input logic             we,
                                          input logic             load);
        dst_tag_t t;
        t.dst  = dst;
        t.we   = we & (dst != REG_ZERO);
        t.load = load;
        return t;
    endfunction

endpackage

// File: rtl/muldiv_busy_ctr.sv
// Down-counter tracking how long the multi-cycle HI/LO unit stays busy after
// a mult/div issues; reloads on issue and saturates at zero.
module muldiv_busy_ctr
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [BUSY_W-1:0] value,
    output logic              busy
);

    logic [BUSY_W-1:0] cnt_q;
    logic [BUSY_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - BUSY_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock and EX/MEM/WB destination-tag tracker for the 5-stage core.
// Define MULDIV_INTERLOCK_EN to add the busy-counter interlock for a multi-cycle HI/LO unit.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MULDIV_LAT = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             id_is_muldiv,
    input  logic             id_reads_hilo,
    input  logic             flush,
    output logic             stall,
    output logic             ex_bubble,
    output logic [REG_W-1:0] mem_dst,
    output logic             mem_we,
    output logic [REG_W-1:0] wb_dst,
    output logic             wb_we
);

    dst_tag_t         ex_q,  ex_d;
    logic [REG_W-1:0] mem_dst_q, mem_dst_d;
    logic             mem_we_q,  mem_we_d;
    logic [REG_W-1:0] wb_dst_q,  wb_dst_d;
    logic             wb_we_q,   wb_we_d;

    logic load_use;
    logic muldiv_hz;
    logic rs_hit;
    logic rt_hit;

    // A load still in EX cannot be bypassed yet; one bubble lets it reach MEM.
    always_comb begin
        rs_hit    = id_rs_used & (id_rs == ex_q.dst);
        rt_hit    = id_rt_used & (id_rt == ex_q.dst);
        load_use  = ex_q.we & ex_q.load & (rs_hit | rt_hit);
        stall     = id_valid & ~flush & (load_use | muldiv_hz);
        ex_bubble = stall | flush | ~id_valid;
    end

`ifdef MULDIV_INTERLOCK_EN
    localparam logic [BUSY_W-1:0] MULDIV_VALUE = BUSY_W'(MULDIV_LAT);

    logic md_issue;
    logic md_busy;

    assign md_issue  = ~ex_bubble & id_is_muldiv;
    assign muldiv_hz = md_busy & id_valid & (id_reads_hilo | id_is_muldiv);

    muldiv_busy_ctr u_busy_ctr (
        .clk   (clk),
        .rst   (rst),
        .load  (md_issue),
        .value (MULDIV_VALUE),
        .busy  (md_busy)
    );
`else
    logic unused_hilo;

    assign unused_hilo = id_is_muldiv ^ id_reads_hilo;
    assign muldiv_hz   = 1'b0;
`endif

    always_comb begin
        if (ex_bubble) begin
            ex_d = '0;
        end else begin
            ex_d = make_tag(id_dst, id_we & id_valid, id_is_load);
        end
        mem_dst_d = ex_q.dst;
        mem_we_d  = ex_q.we;
        wb_dst_d  = mem_dst_q;
        wb_we_d   = mem_we_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            mem_dst_q <= '0;
            mem_we_q  <= 1'b0;
            wb_dst_q  <= '0;
            wb_we_q   <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            mem_dst_q <= mem_dst_d;
            mem_we_q  <= mem_we_d;
            wb_dst_q  <= wb_dst_d;
            wb_we_q   <= wb_we_d;
        end
    end

    assign mem_dst = mem_dst_q;
    assign mem_we  = mem_we_q;
    assign wb_dst  = wb_dst_q;
    assign wb_we   = wb_we_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed test-plan scenarios followed by
// random instruction streams, all checked against an issue-history model.
module tb_hazard_ctrl;

`ifdef MULDIV_INTERLOCK_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif
    localparam int LAT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_dst = '0;
    logic       id_rs_used = 1'b0, id_rt_used = 1'b0, id_we = 1'b0;
    logic       id_is_load = 1'b0, id_is_muldiv = 1'b0, id_reads_hilo = 1'b0, flush = 1'b0;
    logic       stall, ex_bubble, mem_we, wb_we;
    logic [4:0] mem_dst, wb_dst;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULDIV_LAT(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rs_used    (id_rs_used),
        .id_rt_used    (id_rt_used),
        .id_dst        (id_dst),
        .id_we         (id_we),
        .id_is_load    (id_is_load),
        .id_is_muldiv  (id_is_muldiv),
        .id_reads_hilo (id_reads_hilo),
        .flush         (flush),
        .stall         (stall),
        .ex_bubble     (ex_bubble),
        .mem_dst       (mem_dst),
        .mem_we        (mem_we),
        .wb_dst        (wb_dst),
        .wb_we         (wb_we)
    );

    typedef struct {
        logic       rst, valid;
        logic [4:0] rs, rt, dst;
        logic       rs_used, rt_used, we, load, muldiv, hilo, flush;
    } stim_t;

    typedef struct {
        logic [4:0] dst;
        logic       we;
        logic       load;
    } instr_t;

    // history[0] is the instruction now in EX, [1] in MEM, [2] in WB
    instr_t history[3];
    int     edges = 0;
    int     md_issue_edge = -1000;
    int     checks = 0;
    int     failures = 0;
    stim_t  cur;
    bit     exp_stall, exp_bubble;

    function automatic stim_t nop();
        stim_t s;
        s = '{default: '0};
        s.valid = 1'b1;
        return s;
    endfunction

    function automatic stim_t alu(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
        stim_t s;
        s = nop();
        s.dst = d; s.we = 1'b1; s.rs = a; s.rt = b; s.rs_used = 1'b1; s.rt_used = 1'b1;
        return s;
    endfunction

    function automatic stim_t ld(input logic [4:0] d, input logic [4:0] base);
        stim_t s;
        s = nop();
        s.dst = d; s.we = 1'b1; s.load = 1'b1; s.rs = base; s.rs_used = 1'b1;
        return s;
    endfunction

    function automatic stim_t md();
        stim_t s;
        s = alu(5'd0, 5'd3, 5'd4);
        s.we = 1'b0; s.muldiv = 1'b1;
        return s;
    endfunction

    function automatic stim_t mfhi(input logic [4:0] d);
        stim_t s;
        s = nop();
        s.dst = d; s.we = 1'b1; s.hilo = 1'b1;
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s.rst     = ($urandom_range(0, 99) < 2);
        s.valid   = ($urandom_range(0, 99) < 85);
        s.rs      = 5'($urandom_range(0, 3));
        s.rt      = 5'($urandom_range(0, 3));
        s.dst     = 5'($urandom_range(0, 3));
        s.rs_used = 1'($urandom_range(0, 1));
        s.rt_used = 1'($urandom_range(0, 1));
        s.we      = ($urandom_range(0, 99) < 80);
        s.load    = ($urandom_range(0, 99) < 40);
        s.muldiv  = ($urandom_range(0, 99) < 8);
        s.hilo    = ($urandom_range(0, 99) < 15);
        s.flush   = ($urandom_range(0, 99) < 10);
        return s;
    endfunction

    task automatic checkOne(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        cur           = s;
        rst           = s.rst;
        id_valid      = s.valid;
        id_rs         = s.rs;
        id_rt         = s.rt;
        id_rs_used    = s.rs_used;
        id_rt_used    = s.rt_used;
        id_dst        = s.dst;
        id_we         = s.we;
        id_is_load    = s.load;
        id_is_muldiv  = s.muldiv;
        id_reads_hilo = s.hilo;
        flush         = s.flush;
        #1;
    endtask

    task automatic checkOutput();
        instr_t ex;
        bit lu, hilo_busy;
        ex         = history[0];
        lu         = ex.we && ex.load &&
                     ((cur.rs_used && cur.rs == ex.dst) || (cur.rt_used && cur.rt == ex.dst));
        hilo_busy  = FEAT && (edges - md_issue_edge < LAT) && (cur.hilo || cur.muldiv);
        exp_stall  = cur.valid && !cur.flush && (lu || hilo_busy);
        exp_bubble = exp_stall || cur.flush || !cur.valid;
        checkOne("stall",     8'(stall),     8'(exp_stall));
        checkOne("ex_bubble", 8'(ex_bubble), 8'(exp_bubble));
        checkOne("mem_dst",   8'(mem_dst),   8'(history[1].dst));
        checkOne("mem_we",    8'(mem_we),    8'(history[1].we));
        checkOne("wb_dst",    8'(wb_dst),    8'(history[2].dst));
        checkOne("wb_we",     8'(wb_we),     8'(history[2].we));
    endtask

    task automatic modelAdvance();
        instr_t issued;
        edges++;
        if (cur.rst) begin
            history       = '{default: '{dst: '0, we: 1'b0, load: 1'b0}};
            md_issue_edge = -1000;
        end else begin
            if (exp_bubble) begin
                issued = '{dst: '0, we: 1'b0, load: 1'b0};
            end else begin
                issued = '{dst: cur.dst, we: cur.we && cur.dst != 0, load: cur.load};
                if (cur.muldiv) md_issue_edge = edges;
            end
            history[2] = history[1];
            history[1] = history[0];
            history[0] = issued;
        end
    endtask

    task automatic runCycle(input stim_t s);
        applyStimulus(s);
        checkOutput();
        modelAdvance();
    endtask

    initial begin
        stim_t s;
        int    stall_cycles;
        history = '{default: '{dst: '0, we: 1'b0, load: 1'b0}};

        s = nop(); s.rst = 1'b1;
        runCycle(s);
        runCycle(s);
        checkOne("reset_mem_we", 8'(mem_we), 8'd0);
        checkOne("reset_wb_we",  8'(wb_we),  8'd0);

        $display("[TB] load-use");
        runCycle(ld(5'd5, 5'd1));
        runCycle(alu(5'd6, 5'd5, 5'd7));
        checkOne("lu_stall",  8'(stall),     8'd1);
        checkOne("lu_bubble", 8'(ex_bubble), 8'd1);
        runCycle(alu(5'd6, 5'd5, 5'd7));
        checkOne("lu_release", 8'(stall),   8'd0);
        checkOne("lu_mem_dst", 8'(mem_dst), 8'd5);
        checkOne("lu_mem_we",  8'(mem_we),  8'd1);
        repeat (3) runCycle(nop());

        $display("[TB] alu producer");
        runCycle(alu(5'd5, 5'd1, 5'd2));
        runCycle(alu(5'd8, 5'd5, 5'd5));
        checkOne("alu_no_stall", 8'(stall), 8'd0);
        runCycle(nop());
        checkOne("alu_mem_dst", 8'(mem_dst), 8'd5);
        runCycle(nop());
        checkOne("alu_wb_dst", 8'(wb_dst), 8'd5);

        $display("[TB] zero destination");
        runCycle(ld(5'd0, 5'd1));
        runCycle(alu(5'd6, 5'd0, 5'd0));
        checkOne("zero_no_stall", 8'(stall), 8'd0);
        runCycle(nop());
        checkOne("zero_mem_we", 8'(mem_we), 8'd0);
        runCycle(nop());
        checkOne("zero_wb_we", 8'(wb_we), 8'd0);

        $display("[TB] muldiv then mfhi");
        runCycle(md());
        stall_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            runCycle(mfhi(5'd2));
            if (stall !== 1'b1) break;
            stall_cycles++;
        end
        checkOne("mfhi_stall_len", 8'(stall_cycles), FEAT ? 8'(LAT) : 8'd0);
        repeat (2) runCycle(nop());

        $display("[TB] flush during load-use");
        runCycle(ld(5'd5, 5'd1));
        s = alu(5'd6, 5'd5, 5'd7); s.flush = 1'b1;
        runCycle(s);
        checkOne("flush_stall",  8'(stall),     8'd0);
        checkOne("flush_bubble", 8'(ex_bubble), 8'd1);
        runCycle(nop());
        runCycle(nop());
        checkOne("flush_mem_we", 8'(mem_we), 8'd0);

        $display("[TB] reset during muldiv stall");
        runCycle(md());
        runCycle(mfhi(5'd2));
        checkOne("md_stall_before_rst", 8'(stall), 8'(FEAT));
        s = mfhi(5'd2); s.rst = 1'b1;
        runCycle(s);
        runCycle(mfhi(5'd2));
        checkOne("rst_stall",  8'(stall),  8'd0);
        checkOne("rst_mem_we", 8'(mem_we), 8'd0);
        checkOne("rst_wb_we",  8'(wb_we),  8'd0);

        $display("[TB] random stream");
        for (int i = 0; i < 800; i++) begin
            runCycle(randStim());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
